// File: rtl/pipe_bus_pkg.sv
// Field layouts of the EXE->MEM and MEM->WB pipeline buses, plus the MEM-stage
// entry record and state encoding.
package pipe_bus_pkg;

  localparam int ES_TO_MS_BUS_W = 232;
  localparam int MS_TO_WS_BUS_W = 104;
  localparam int MS_FWD_BUS_W   = 39;
  localparam int CSR_EXT_W      = 121;
  localparam int CSR_WB_W       = 30;
  localparam int LD_OP_W        = 5;

  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          result;
    logic [4:0]           dest;
    logic                 gr_we;
    logic                 res_from_mem;
    logic [LD_OP_W-1:0]   ld_op;
    logic                 mem_req;
    logic                 ex;
    logic                 ertn;
    logic                 refetch;
    logic                 wr_asid_ehi;
    logic [CSR_EXT_W-1:0] csr_ext;  // badv / csr wmask / wvalue, not needed past MEM
    logic [CSR_WB_W-1:0]  csr_wb;   // {csr_we, csr_num, ecode, esubcode}
  } es_to_ms_t;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         final_result;
    logic [4:0]          dest;
    logic                gr_we;
    logic                ex;
    logic                ertn;
    logic                refetch;
    logic                wr_asid_ehi;
    logic [CSR_WB_W-1:0] csr_wb;
  } ms_to_ws_t;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         result;
    logic [4:0]          dest;
    logic                gr_we;
    logic                res_from_mem;
    logic [LD_OP_W-1:0]  ld_op;
    logic                ex;
    logic                ertn;
    logic                refetch;
    logic                wr_asid_ehi;
    logic [CSR_WB_W-1:0] csr_wb;
  } ms_entry_t;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_READY = 2'd1,
    MS_WAIT  = 2'd2,
    MS_HOLD  = 2'd3
  } ms_state_e;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load response and sign/zero-extends it.
module load_align
  import pipe_bus_pkg::*;
(
  input  logic [31:0]        rdata,
  input  logic [1:0]         sel,
  input  logic [LD_OP_W-1:0] ld_op,
  output logic [31:0]        data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[gi*8 +: 8];
    end
  endgenerate

  assign byte_sel = lane[sel];
  assign half_sel = sel[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    if (ld_op[LD_B])       data = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op[LD_BU]) data = {24'h0, byte_sel};
    else if (ld_op[LD_H])  data = {{16{half_sel[15]}}, half_sel};
    else if (ld_op[LD_HU]) data = {16'h0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: tracks the data-SRAM request issued by EXE, discards responses
// belonging to flushed requests, aligns load data and hands completed entries to WB.
module mem_stage
  import pipe_bus_pkg::*;
#(
  parameter int ES_TO_MS_W = ES_TO_MS_BUS_W,
  parameter int MS_TO_WS_W = MS_TO_WS_BUS_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    es_to_ms_valid,
  input  logic [ES_TO_MS_W-1:0]   es_to_ms_bus,
  output logic                    ms_allowin,
  input  logic                    ws_allowin,
  output logic                    ms_to_ws_valid,
  output logic [MS_TO_WS_W-1:0]   ms_to_ws_bus,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    wb_ex,
  input  logic                    wb_ertn,
  input  logic                    wb_refetch,
  output logic                    mem_ex,
  output logic                    mem_ertn,
  output logic                    mem_refetch,
  output logic                    mem_write_asid_ehi,
  output logic [MS_FWD_BUS_W-1:0] ms_fwd_bus
);

  es_to_ms_t  es_in;
  ms_to_ws_t  ws_out;
  ms_entry_t  entry_reg, entry_next;
  ms_state_e  state_reg, state_next;
  logic [1:0] drop_cnt_reg, drop_cnt_next;
  logic [2:0] drop_sum;
  logic [31:0] rdata_buf_reg;
  logic [31:0] load_rdata;
  logic [31:0] aligned_data;
  logic [31:0] final_result;
  logic flush, ms_valid, ms_ready_go, capture, resp_live, latch_rdata;
  logic drop_inc_cur, drop_inc_new, drop_dec, gr_we_eff;
  logic unused_csr_ext;

  assign es_in          = es_to_ms_bus;
  assign unused_csr_ext = ^es_in.csr_ext;

  assign flush          = wb_ex | wb_ertn | wb_refetch;
  // A response only belongs to the current entry once all stale ones have drained.
  assign resp_live      = data_sram_data_ok && (drop_cnt_reg == 2'd0);
  assign ms_valid       = (state_reg != MS_EMPTY);
  assign ms_ready_go    = (state_reg != MS_WAIT) || resp_live;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign capture        = es_to_ms_valid && ms_allowin && !flush;
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= MS_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (capture) begin
      state_next = es_in.mem_req ? MS_WAIT : MS_READY;
    end else if (flush || ms_allowin) begin
      state_next = MS_EMPTY;
    end else if ((state_reg == MS_WAIT) && resp_live) begin
      state_next = MS_HOLD;
    end
  end

  assign latch_rdata = (state_reg == MS_WAIT) && (state_next == MS_HOLD);

  // Every request that will never be consumed by a live entry adds one response to discard.
  assign drop_inc_cur = flush && (state_reg == MS_WAIT) && !resp_live;
  assign drop_inc_new = flush && es_to_ms_valid && ms_allowin && es_in.mem_req;
  assign drop_dec     = data_sram_data_ok && (drop_cnt_reg != 2'd0);
  assign drop_sum     = {1'b0, drop_cnt_reg} + {2'b0, drop_inc_cur} + {2'b0, drop_inc_new}
                        - {2'b0, drop_dec};
  assign drop_cnt_next = (drop_sum > 3'd2) ? 2'd2 : drop_sum[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_reg <= 2'd0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  always_comb begin
    entry_next              = '0;
    entry_next.pc           = es_in.pc;
    entry_next.result       = es_in.result;
    entry_next.dest         = es_in.dest;
    entry_next.gr_we        = es_in.gr_we;
    entry_next.res_from_mem = es_in.res_from_mem;
    entry_next.ld_op        = es_in.ld_op;
    entry_next.ex           = es_in.ex;
    entry_next.ertn         = es_in.ertn;
    entry_next.refetch      = es_in.refetch;
    entry_next.wr_asid_ehi  = es_in.wr_asid_ehi;
    entry_next.csr_wb       = es_in.csr_wb;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_reg     <= '0;
      rdata_buf_reg <= 32'h0;
    end else begin
      if (capture) begin
        entry_reg <= entry_next;
      end
      if (latch_rdata) begin
        rdata_buf_reg <= data_sram_rdata;
      end
    end
  end

  assign load_rdata = (state_reg == MS_HOLD) ? rdata_buf_reg : data_sram_rdata;

  load_align u_load_align (
    .rdata (load_rdata),
    .sel   (entry_reg.result[1:0]),
    .ld_op (entry_reg.ld_op),
    .data  (aligned_data)
  );

  assign final_result = entry_reg.res_from_mem ? aligned_data : entry_reg.result;
  assign gr_we_eff    = entry_reg.gr_we && !entry_reg.ex;

  always_comb begin
    ws_out              = '0;
    ws_out.pc           = entry_reg.pc;
    ws_out.final_result = final_result;
    ws_out.dest         = entry_reg.dest;
    ws_out.gr_we        = gr_we_eff;
    ws_out.ex           = entry_reg.ex;
    ws_out.ertn         = entry_reg.ertn;
    ws_out.refetch      = entry_reg.refetch;
    ws_out.wr_asid_ehi  = entry_reg.wr_asid_ehi;
    ws_out.csr_wb       = entry_reg.csr_wb;
  end

  assign ms_to_ws_bus = ws_out;

  assign mem_ex             = ms_valid && entry_reg.ex;
  assign mem_ertn           = ms_valid && entry_reg.ertn;
  assign mem_refetch        = ms_valid && entry_reg.refetch;
  assign mem_write_asid_ehi = ms_valid && entry_reg.wr_asid_ehi;

  // A load still waiting for data cannot be bypassed; ID has to stall on it.
  assign ms_fwd_bus = {ms_valid && gr_we_eff,
                       ms_valid && entry_reg.res_from_mem && !ms_ready_go,
                       entry_reg.dest,
                       final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed spec scenarios plus a randomized
// load/store/ALU stream compared against a behavioural model.
module tb_mem_stage;
  import pipe_bus_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         es_to_ms_valid = 1'b0;
  logic [231:0] es_to_ms_bus = '0;
  logic         ms_allowin;
  logic         ws_allowin = 1'b1;
  logic         ms_to_ws_valid;
  logic [103:0] ms_to_ws_bus;
  logic         data_sram_data_ok = 1'b0;
  logic [31:0]  data_sram_rdata = 32'h0;
  logic         wb_ex = 1'b0;
  logic         wb_ertn = 1'b0;
  logic         wb_refetch = 1'b0;
  logic         mem_ex, mem_ertn, mem_refetch, mem_write_asid_ehi;
  logic [38:0]  ms_fwd_bus;

  int n_checks = 0;
  int n_fail   = 0;
  // Outstanding SRAM responses in issue order: 1 = belongs to a live entry, 0 = must be discarded.
  bit outst_q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                (clk),
    .reset              (reset),
    .es_to_ms_valid     (es_to_ms_valid),
    .es_to_ms_bus       (es_to_ms_bus),
    .ms_allowin         (ms_allowin),
    .ws_allowin         (ws_allowin),
    .ms_to_ws_valid     (ms_to_ws_valid),
    .ms_to_ws_bus       (ms_to_ws_bus),
    .data_sram_data_ok  (data_sram_data_ok),
    .data_sram_rdata    (data_sram_rdata),
    .wb_ex              (wb_ex),
    .wb_ertn            (wb_ertn),
    .wb_refetch         (wb_refetch),
    .mem_ex             (mem_ex),
    .mem_ertn           (mem_ertn),
    .mem_refetch        (mem_refetch),
    .mem_write_asid_ehi (mem_write_asid_ehi),
    .ms_fwd_bus         (ms_fwd_bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic es_to_ms_t mk_entry(input logic [31:0] pc, input logic [31:0] result,
                                         input logic [4:0] dest, input logic gr_we,
                                         input logic rfm, input logic [4:0] op,
                                         input logic mreq, input logic ex);
    es_to_ms_t e;
    e              = '0;
    e.pc           = pc;
    e.result       = result;
    e.dest         = dest;
    e.gr_we        = gr_we;
    e.res_from_mem = rfm;
    e.ld_op        = op;
    e.mem_req      = mreq;
    e.ex           = ex;
    e.csr_ext      = 121'({$urandom, $urandom, $urandom, $urandom});
    e.csr_wb       = 30'($urandom);
    return e;
  endfunction

  function automatic logic [31:0] exp_align(input logic [4:0] op, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    int unsigned sel, b, h;
    sel = addr % 4;
    b   = (rdata >> (8 * sel)) % 256;
    h   = (rdata >> (16 * (sel / 2))) % 65536;
    if (op[LD_B])  return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
    if (op[LD_BU]) return 32'(b);
    if (op[LD_H])  return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
    if (op[LD_HU]) return 32'(h);
    return rdata;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (ms_allowin !== 1'b1) begin
      n_fail++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin);
    end
    n_checks++;
    if ({ms_to_ws_valid, mem_ex, mem_ertn, mem_refetch, mem_write_asid_ehi} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                         {ms_to_ws_valid, mem_ex, mem_ertn, mem_refetch, mem_write_asid_ehi});
    end
    n_checks++;
    if (ms_to_ws_bus !== '0 || ms_fwd_bus !== '0) begin
      n_fail++; $display("FAIL reset_buses: got ws=%h fwd=%h expected 0", ms_to_ws_bus, ms_fwd_bus);
    end
    reset = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_ld_w_latency();
    es_to_ms_t e;
    ms_to_ws_t w;
    int blk = 0;
    e = mk_entry(32'h1c00_0040, 32'h100, 5'd4, 1'b1, 1'b1, 5'(1 << LD_W), 1'b1, 1'b0);
    es_to_ms_bus = e; es_to_ms_valid = 1'b1; ws_allowin = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ms_fwd_bus[37] === 1'b1 && ms_to_ws_valid === 1'b0) blk++;
      step();
    end
    n_checks++;
    if (blk != 3) begin
      n_fail++; $display("FAIL ldw_blocked_cycles: got %0d expected 3", blk);
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h89AB_CDEF;
    @(negedge clk);
    w = ms_to_ws_bus;
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_fwd_bus[37] !== 1'b0 || w.final_result !== 32'h89AB_CDEF) begin
      n_fail++; $display("FAIL ldw_result: got v=%b blk=%b res=%h expected v=1 blk=0 res=89abcdef",
                         ms_to_ws_valid, ms_fwd_bus[37], w.final_result);
    end
    step();
    data_sram_data_ok = 1'b0;
    $display("test_ld_w_latency: ld_w 0x100 -> %h", w.final_result);
  endtask

  task automatic test_load_align();
    logic [4:0]  ops  [5] = '{5'(1 << LD_B), 5'(1 << LD_BU), 5'(1 << LD_HU), 5'(1 << LD_H), 5'(1 << LD_B)};
    logic [31:0] adrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF, 32'hFFFF_FFFF};
    es_to_ms_t e;
    ms_to_ws_t w;
    for (int i = 0; i < 5; i++) begin
      e = mk_entry(32'h1c00_1000, adrs[i], 5'd7, 1'b1, 1'b1, ops[i], 1'b1, 1'b0);
      es_to_ms_bus = e; es_to_ms_valid = 1'b1;
      step();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FFFF;
      @(negedge clk);
      w = ms_to_ws_bus;
      n_checks++;
      if (ms_to_ws_valid !== 1'b1 || w.final_result !== exps[i]) begin
        n_fail++; $display("FAIL align_%0d: got v=%b res=%h expected v=1 res=%h",
                           i, ms_to_ws_valid, w.final_result, exps[i]);
      end
      step();
      data_sram_data_ok = 1'b0;
      $display("test_load_align: op=%b addr=%h -> %h", ops[i], adrs[i], w.final_result);
    end
  endtask

  task automatic test_hold();
    es_to_ms_t e;
    ms_to_ws_t w;
    e = mk_entry(32'h1c00_2000, 32'h200, 5'd9, 1'b1, 1'b1, 5'(1 << LD_W), 1'b1, 1'b0);
    es_to_ms_bus = e; es_to_ms_valid = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678; ws_allowin = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin
      n_fail++; $display("FAIL hold_first: got v=%b allowin=%b expected v=1 allowin=0",
                         ms_to_ws_valid, ms_allowin);
    end
    step();
    data_sram_data_ok = 1'b0;
    for (int c = 0; c < 2; c++) begin
      data_sram_rdata = 32'hDEAD_BEEF;
      ws_allowin = (c == 1);
      @(negedge clk);
      w = ms_to_ws_bus;
      n_checks++;
      if (ms_to_ws_valid !== 1'b1 || w.final_result !== 32'h1234_5678 || ms_allowin !== ws_allowin) begin
        n_fail++; $display("FAIL hold_cycle%0d: got v=%b res=%h allowin=%b expected v=1 res=12345678 allowin=%b",
                           c, ms_to_ws_valid, w.final_result, ms_allowin, ws_allowin);
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got v=%b expected 0", ms_to_ws_valid);
    end
    step();
    $display("test_hold: held value released %h", w.final_result);
  endtask

  // Pulse data_ok and compare completion against the outstanding-response model.
  task automatic resp_and_check(input string name, input logic [31:0] rdata, input logic [31:0] exp_res);
    ms_to_ws_t w;
    logic exp_v;
    exp_v = (outst_q.size() > 0) && outst_q[0];
    data_sram_data_ok = 1'b1; data_sram_rdata = rdata;
    @(negedge clk);
    w = ms_to_ws_bus;
    n_checks++;
    if (ms_to_ws_valid !== exp_v || (exp_v && w.final_result !== exp_res)) begin
      n_fail++; $display("FAIL %s: got v=%b res=%h expected v=%b res=%h",
                         name, ms_to_ws_valid, w.final_result, exp_v, exp_res);
    end
    step();
    void'(outst_q.pop_front());
    data_sram_data_ok = 1'b0;
    $display("%s: data_ok rdata=%h valid=%b", name, rdata, exp_v);
  endtask

  task automatic issue_load(input logic [31:0] addr);
    es_to_ms_bus = mk_entry(32'h1c00_3000, addr, 5'd5, 1'b1, 1'b1, 5'(1 << LD_W), 1'b1, 1'b0);
    es_to_ms_valid = 1'b1;
    outst_q.push_back(1'b1);
    step();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic test_flush_drop();
    issue_load(32'h300);
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_fwd_bus[37] !== 1'b1) begin
      n_fail++; $display("FAIL flush_wait: got v=%b blk=%b expected v=0 blk=1", ms_to_ws_valid, ms_fwd_bus[37]);
    end
    step();
    wb_ex = 1'b1;
    foreach (outst_q[i]) outst_q[i] = 1'b0;
    step();
    wb_ex = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_fwd_bus[38:37] !== 2'b00) begin
      n_fail++; $display("FAIL flush_empty_after: got allowin=%b v=%b fwd=%b expected 1 0 00",
                         ms_allowin, ms_to_ws_valid, ms_fwd_bus[38:37]);
    end
    issue_load(32'h304);
    resp_and_check("flush_stale", 32'h5555_0000, 32'h0);
    resp_and_check("flush_real", 32'hA5A5_1234, 32'hA5A5_1234);

    // Flush in the same cycle as the current entry's own response: nothing left to drop.
    issue_load(32'h308);
    wb_ertn = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    step();
    void'(outst_q.pop_front());
    wb_ertn = 1'b0; data_sram_data_ok = 1'b0;
    issue_load(32'h30c);
    resp_and_check("flush_same_cycle_next", 32'h2222_2222, 32'h2222_2222);
  endtask

  task automatic test_flush_empty();
    es_to_ms_bus = mk_entry(32'h1c00_4000, 32'h400, 5'd6, 1'b1, 1'b1, 5'(1 << LD_W), 1'b1, 1'b0);
    es_to_ms_valid = 1'b1; wb_refetch = 1'b1;
    outst_q.push_back(1'b0);
    step();
    es_to_ms_valid = 1'b0; wb_refetch = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || mem_refetch !== 1'b0) begin
      n_fail++; $display("FAIL flush_nocapture: got v=%b allowin=%b expected v=0 allowin=1",
                         ms_to_ws_valid, ms_allowin);
    end
    // Second dead request while one is already outstanding: two responses to discard.
    issue_load(32'h404);
    wb_refetch = 1'b1;
    foreach (outst_q[i]) outst_q[i] = 1'b0;
    step();
    wb_refetch = 1'b0;
    issue_load(32'h408);
    resp_and_check("drop_first", 32'h3333_0000, 32'h0);
    resp_and_check("drop_second", 32'h4444_0000, 32'h0);
    resp_and_check("drop_then_live", 32'h6666_7777, 32'h6666_7777);
  endtask

  task automatic test_exception();
    es_to_ms_t e;
    ms_to_ws_t w;
    e = mk_entry(32'h1c00_5000, 32'hCAFE_0000, 5'd11, 1'b1, 1'b0, 5'b0, 1'b0, 1'b1);
    es_to_ms_bus = e; es_to_ms_valid = 1'b1; ws_allowin = 1'b0;
    step();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    w = ms_to_ws_bus;
    n_checks++;
    if (mem_ex !== 1'b1 || ms_fwd_bus[38] !== 1'b0 || w.gr_we !== 1'b0 || w.ex !== 1'b1 || ms_to_ws_valid !== 1'b1) begin
      n_fail++; $display("FAIL ex_entry: got mem_ex=%b we_vld=%b gr_we=%b ex=%b v=%b expected 1 0 0 1 1",
                         mem_ex, ms_fwd_bus[38], w.gr_we, w.ex, ms_to_ws_valid);
    end
    ws_allowin = 1'b1;
    e = mk_entry(32'h1c00_5004, 32'h5, 5'd12, 1'b1, 1'b0, 5'b0, 1'b0, 1'b0);
    e.ertn = 1'b1; e.refetch = 1'b1; e.wr_asid_ehi = 1'b1;
    es_to_ms_bus = e; es_to_ms_valid = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_ex, mem_ertn, mem_refetch, mem_write_asid_ehi, ms_fwd_bus[38]} !== 5'b01111) begin
      n_fail++; $display("FAIL status_flags: got %b expected 01111",
                         {mem_ex, mem_ertn, mem_refetch, mem_write_asid_ehi, ms_fwd_bus[38]});
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({mem_ex, mem_ertn, mem_refetch, mem_write_asid_ehi} !== 4'b0) begin
      n_fail++; $display("FAIL status_cleared: got %b expected 0000",
                         {mem_ex, mem_ertn, mem_refetch, mem_write_asid_ehi});
    end
    step();
    $display("test_exception done");
  endtask

  task automatic test_async_reset();
    issue_load(32'h500);
    void'(outst_q.pop_front());
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_fwd_bus !== '0 || ms_to_ws_bus !== '0) begin
      n_fail++; $display("FAIL async_reset: got allowin=%b v=%b fwd=%h ws=%h expected 1 0 0 0",
                         ms_allowin, ms_to_ws_valid, ms_fwd_bus, ms_to_ws_bus);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      n_fail++; $display("FAIL reset_ignore_resp: got v=%b allowin=%b expected 0 1", ms_to_ws_valid, ms_allowin);
    end
    step();
    data_sram_data_ok = 1'b0;
    issue_load(32'h504);
    resp_and_check("post_reset_load", 32'h8888_9999, 32'h8888_9999);
  endtask

  task automatic test_random_ops();
    es_to_ms_t   e;
    ms_to_ws_t   w;
    int          kind, wait_cyc, stall;
    logic [31:0] rdata, exp_res;
    logic [4:0]  op;
    for (int n = 0; n < 40; n++) begin
      kind     = $urandom_range(0, 2);          // 0 alu, 1 load, 2 store
      op       = (kind == 1) ? 5'(1 << $urandom_range(0, 4)) : 5'b0;
      e        = mk_entry($urandom, $urandom, 5'($urandom), 1'($urandom), kind == 1, op, kind != 0, 1'b0);
      rdata    = $urandom;
      wait_cyc = $urandom_range(0, 3);
      stall    = $urandom_range(0, 2);
      exp_res  = (kind == 1) ? exp_align(op, e.result, rdata) : e.result;
      es_to_ms_bus = e; es_to_ms_valid = 1'b1; ws_allowin = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ms_allowin !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_allowin: got %b expected 1", n, ms_allowin);
      end
      step();
      es_to_ms_valid = 1'b0;
      if (kind != 0) begin
        for (int c = 0; c < wait_cyc; c++) begin
          @(negedge clk);
          n_checks++;
          if (ms_to_ws_valid !== 1'b0 || ms_fwd_bus[37] !== (kind == 1)) begin
            n_fail++; $display("FAIL rnd%0d_wait: got v=%b blk=%b expected v=0 blk=%b",
                               n, ms_to_ws_valid, ms_fwd_bus[37], kind == 1);
          end
          step();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = rdata;
      end
      ws_allowin = (stall == 0);
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        w = ms_to_ws_bus;
        n_checks++;
        if (ms_to_ws_valid !== 1'b1 || w.final_result !== exp_res || w.gr_we !== e.gr_we ||
            w.dest !== e.dest || w.pc !== e.pc || w.csr_wb !== e.csr_wb) begin
          n_fail++; $display("FAIL rnd%0d_out: got v=%b res=%h we=%b dest=%0d expected v=1 res=%h we=%b dest=%0d",
                             n, ms_to_ws_valid, w.final_result, w.gr_we, w.dest, exp_res, e.gr_we, e.dest);
        end
        step();
        data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        ws_allowin = (s + 1 == stall);
      end
      ws_allowin = 1'b1;
      $display("rnd %0d: kind=%0d op=%b addr=%h wait=%0d stall=%0d res=%h", n, kind, op, e.result,
               wait_cyc, stall, exp_res);
    end
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_ld_w_latency();
    test_load_align();
    test_hold();
    test_flush_drop();
    test_flush_empty();
    test_exception();
    test_async_reset();
    test_random_ops();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
